// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM states and bus constants for the I2C register-file slave
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEVADDR,
    ST_ACK,
    ST_REGPTR,
    ST_WRDATA,
    ST_RDDATA,
    ST_RDACK,
    ST_WAITSTOP
  } i2c_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - scl/sda synchroniser, optional majority filter (I2C_GLITCH_FILTER_EN),
// SCL edge and START/STOP detection
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s;
  logic scl_prev_q, sda_prev_q;

  // Idle bus is pulled high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic scl_filt_q, sda_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C slave exposing DEPTH 8-bit registers with auto-increment pointer;
// I2C_GLITCH_FILTER_EN enables the bus input majority filter
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  inout  wire                      sda,
  input  logic [6:0]               dev_addr,
  input  logic [$clog2(DEPTH)-1:0] host_idx,
  output logic [7:0]               host_rdata,
  output logic                     wr_pulse,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int IW = $clog2(DEPTH);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  i2c_state_t state_q, state_d, ack_next_q, ack_next_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d, wr_data_q, wr_data_d;
  logic [IW-1:0] ptr_q, ptr_d, wr_idx_q, wr_idx_d, ptr_nxt;
  logic          ok_q, ok_d, rw_q, rw_d, sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d, wr_pulse_q, wr_pulse_d;
  logic [7:0]    regs_q [DEPTH];
  logic [7:0]    byte_in;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign byte_in = {shift_q[6:0], sda_s};
  assign ptr_nxt = ptr_inc(ptr_q);

  always_comb begin
    state_d    = state_q;
    ack_next_d = ack_next_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ok_d       = ok_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    if (stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d   = ST_DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_DEVADDR, ST_REGPTR, ST_WRDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_DEVADDR) begin
                ok_d = (byte_in[7:1] == dev_addr);
                rw_d = byte_in[0];
                if (byte_in[7:1] == dev_addr) busy_d = 1'b1;
              end else if (state_q == ST_REGPTR) begin
                ok_d = ({24'd0, byte_in} < 32'(DEPTH));
                if ({24'd0, byte_in} < 32'(DEPTH)) ptr_d = byte_in[IW-1:0];
              end else begin
                ok_d       = 1'b1;
                wr_pulse_d = 1'b1;
                wr_idx_d   = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_nxt;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (ok_q) begin
              sda_oe_d = 1'b1;
              state_d  = ST_ACK;
              if (state_q == ST_DEVADDR)
                ack_next_d = (rw_q == I2C_RW_WRITE) ? ST_REGPTR : ST_RDDATA;
              else
                ack_next_d = ST_WRDATA;
            end else begin
              state_d = ST_WAITSTOP;
            end
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            state_d   = ack_next_q;
            if (ack_next_q == ST_RDDATA) begin
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_RDDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RDACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RDACK: begin
          if (scl_rise) begin
            ok_d = (sda_s == I2C_ACK);
          end else if (scl_fall) begin
            if (ok_q) begin
              ptr_d     = ptr_nxt;
              shift_d   = regs_q[ptr_nxt];
              sda_oe_d  = ~regs_q[ptr_nxt][7];
              bit_cnt_d = '0;
              state_d   = ST_RDDATA;
            end else begin
              state_d = ST_WAITSTOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ack_next_q <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ok_q       <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_next_q <= ack_next_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ok_q       <= ok_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_pulse_d) begin
      regs_q[wr_idx_d] <= wr_data_d;
    end
  end

  // Open-drain: only ever pull low; the async reset clears sda_oe_q immediately.
  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign host_rdata = regs_q[host_idx];
  assign wr_pulse   = wr_pulse_q;
  assign wr_idx     = wr_idx_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;

endmodule
